// File: rtl/posit_mul_core.sv
// rtl/posit_mul_core.sv - two-stage posit multiplier core: scale add, significand multiply, normalize.
// Optional macro POSIT_MUL_STICKY_EN enables the sticky (discarded product bits) output.
module posit_mul_core #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N),
  localparam int SW = RS + ES + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          SignA,
  input  logic          SignB,
  input  logic [RS:0]   kA,
  input  logic [RS:0]   kB,
  input  logic [ES-1:0] ExponentA,
  input  logic [ES-1:0] ExponentB,
  input  logic [N-1:0]  MantissaA,
  input  logic [N-1:0]  MantissaB,
  input  logic          NaRA,
  input  logic          NaRB,
  input  logic          zeroA,
  input  logic          zeroB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          Sign,
  output logic [SW-1:0] Scale,
  output logic [N-1:0]  Mantissa,
  output logic          Sticky,
  output logic          NaR,
  output logic          zero
);

`ifdef POSIT_MUL_STICKY_EN
  localparam int PW = 2 * N;
`else
  // Only the bits that can reach Mantissa are kept when sticky is disabled.
  localparam int PW = N + 1;
`endif

  function automatic logic [SW-1:0] op_scale(input logic [RS:0] k, input logic [ES-1:0] e);
    logic [SW-1:0] ks;
    ks = {{(SW-RS-1){k[RS]}}, k};
    return (ks << ES) + {{(SW-ES){1'b0}}, e};
  endfunction

  logic          en;
  logic [PW-1:0] prod_in;
  logic          s1_valid;
  logic          s1_sign;
  logic [SW-1:0] s1_scale;
  logic [PW-1:0] s1_prod;
  logic          s1_nar;
  logic          s1_zero;
  logic [N:0]    hi;
  logic          top;
  logic          special;
  logic [N-1:0]  mant_nx;
  logic [SW-1:0] scale_nx;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef POSIT_MUL_STICKY_EN
  assign prod_in = {{N{1'b0}}, MantissaA} * {{N{1'b0}}, MantissaB};
`else
  assign prod_in = PW'(({{N{1'b0}}, MantissaA} * {{N{1'b0}}, MantissaB}) >> (N - 1));
`endif

  assign hi       = s1_prod[PW-1:PW-N-1];
  assign top      = hi[N];
  assign special  = s1_nar || s1_zero;
  assign mant_nx  = top ? hi[N:1] : hi[N-1:0];
  assign scale_nx = s1_scale + {{(SW-1){1'b0}}, top};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_scale  <= '0;
      s1_prod   <= '0;
      s1_nar    <= 1'b0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      Sign      <= 1'b0;
      Scale     <= '0;
      Mantissa  <= '0;
      NaR       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign   <= SignA ^ SignB;
      s1_scale  <= op_scale(kA, ExponentA) + op_scale(kB, ExponentB);
      s1_prod   <= prod_in;
      s1_nar    <= NaRA || NaRB;
      s1_zero   <= !(NaRA || NaRB) && (zeroA || zeroB);
      out_valid <= s1_valid;
      Sign      <= special ? 1'b0 : s1_sign;
      Scale     <= special ? '0 : scale_nx;
      Mantissa  <= special ? '0 : mant_nx;
      NaR       <= s1_nar;
      zero      <= s1_zero;
    end
  end

`ifdef POSIT_MUL_STICKY_EN
  logic sticky_nx;
  assign sticky_nx = top ? (|s1_prod[N-1:0]) : (|s1_prod[N-2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      Sticky <= 1'b0;
    end else if (en) begin
      Sticky <= special ? 1'b0 : sticky_nx;
    end
  end
`else
  assign Sticky = 1'b0;
`endif

endmodule

// File: tb/tb_posit_mul_core.sv
// tb/tb_posit_mul_core.sv - randomized and directed self-checking bench for posit_mul_core.
module tb_posit_mul_core;
  localparam int N   = 32;
  localparam int ES  = 2;
  localparam int RS  = $clog2(N);
  localparam int SW  = RS + ES + 3;
  localparam int PAD = 64 - SW - N - 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic SignA = 1'b0, SignB = 1'b0;
  logic [RS:0] kA = '0, kB = '0;
  logic [ES-1:0] ExponentA = '0, ExponentB = '0;
  logic [N-1:0] MantissaA = '0, MantissaB = '0;
  logic NaRA = 1'b0, NaRB = 1'b0, zeroA = 1'b0, zeroB = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic Sign, Sticky, NaR, zero;
  logic [SW-1:0] Scale;
  logic [N-1:0] Mantissa;

  int checks = 0;
  int errors = 0;

  logic        n_sa, n_sb, n_nara, n_narb, n_za, n_zb;
  int          n_ka, n_kb, n_ea, n_eb;
  logic [N-1:0] n_ma, n_mb;
  logic [63:0] exp_q[$];
  logic [63:0] held_val;
  logic        held_flag = 1'b0;
  int          delivered = 0;

  always #5 clk = ~clk;

  posit_mul_core #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .SignA(SignA), .SignB(SignB), .kA(kA), .kB(kB),
    .ExponentA(ExponentA), .ExponentB(ExponentB),
    .MantissaA(MantissaA), .MantissaB(MantissaB),
    .NaRA(NaRA), .NaRB(NaRB), .zeroA(zeroA), .zeroB(zeroB),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sign(Sign), .Scale(Scale), .Mantissa(Mantissa), .Sticky(Sticky),
    .NaR(NaR), .zero(zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] observed();
    return {PAD'(0), Sign, Scale, Mantissa, Sticky, NaR, zero};
  endfunction

  // Reference: real scale is k*2^ES+e per operand; product normalized to [1,2).
  function automatic logic [63:0] model(input logic sa, input logic sb, input int ka, input int kb,
                                        input int ea, input int eb, input logic [N-1:0] ma,
                                        input logic [N-1:0] mb, input logic nara, input logic narb,
                                        input logic za, input logic zb);
    logic [63:0] p;
    int          sc;
    logic [N-1:0] m;
    logic        st, nar, zr, sg;
    nar = nara | narb;
    zr  = !nar && (za || zb);
    p   = 64'(ma) * 64'(mb);
    sc  = ka * (1 << ES) + ea + kb * (1 << ES) + eb;
    sg  = sa ^ sb;
    if (p[2*N-1]) begin
      sc = sc + 1;
      m  = p[2*N-1:N];
      st = (p[N-1:0] != 0);
    end else begin
      m  = p[2*N-2:N-1];
      st = (p[N-2:0] != 0);
    end
`ifndef POSIT_MUL_STICKY_EN
    st = 1'b0;
`endif
    if (nar || zr) begin
      sg = 1'b0; sc = 0; m = '0; st = 1'b0;
    end
    return {PAD'(0), sg, SW'(sc), m, st, nar, zr};
  endfunction

  task automatic set_op(input logic sa, input int ka, input int ea, input logic [N-1:0] ma,
                        input logic sb, input int kb, input int eb, input logic [N-1:0] mb,
                        input logic nara, input logic narb, input logic za, input logic zb);
    n_sa = sa; n_ka = ka; n_ea = ea; n_ma = ma;
    n_sb = sb; n_kb = kb; n_eb = eb; n_mb = mb;
    n_nara = nara; n_narb = narb; n_za = za; n_zb = zb;
  endtask

  // One cycle: drive at negedge, then account for the handshakes of the coming posedge.
  task automatic step(input logic iv, input logic ordy);
    @(negedge clk);
    SignA = n_sa; kA = (RS+1)'(n_ka); ExponentA = ES'(n_ea); MantissaA = n_ma;
    SignB = n_sb; kB = (RS+1)'(n_kb); ExponentB = ES'(n_eb); MantissaB = n_mb;
    NaRA = n_nara; NaRB = n_narb; zeroA = n_za; zeroB = n_zb;
    in_valid = iv;
    out_ready = ordy;
    #1;
    if (held_flag) check("hold", observed(), held_val);
    if (out_valid && !out_ready) begin
      held_flag = 1'b1;
      held_val  = observed();
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end else begin
      held_flag = 1'b0;
    end
    if (in_valid && in_ready)
      exp_q.push_back(model(n_sa, n_sb, n_ka, n_kb, n_ea, n_eb, n_ma, n_mb, n_nara, n_narb, n_za, n_zb));
    if (out_valid && out_ready) begin
      delivered++;
      if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
      else check("result", observed(), exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_fields", observed(), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    held_flag = 1'b0;
    exp_q.delete();
    delivered = 0;
  endtask

  initial begin
    set_op(0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0);
    do_reset();

    // 1 x 1 with exact latency
    step(1, 0);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    step(0, 1);
    check("lat_early", 64'(out_valid), 64'd0);
    step(0, 1);
    check("lat_two", 64'(out_valid), 64'd1);
    check("one_mant", 64'(Mantissa), 64'h8000_0000);
    check("one_scale", 64'(Scale), 64'd0);
    check("one_sign_sticky", {62'd0, Sign, Sticky}, 64'd0);

    set_op(0, 0, 0, 32'hC000_0000, 0, 0, 0, 32'hC000_0000, 0, 0, 0, 0);
    step(1, 1); step(0, 1); step(0, 1);
    check("1p5_scale", 64'(Scale), 64'd1);
    check("1p5_mant", 64'(Mantissa), 64'h9000_0000);
    check("1p5_sticky", 64'(Sticky), 64'd0);

    set_op(1, 1, 1, 32'h8000_0000, 0, -1, 3, 32'h8000_0000, 0, 0, 0, 0);
    step(1, 1); step(0, 1); step(0, 1);
    check("mix_scale", 64'(Scale), 64'd4);
    check("mix_sign", 64'(Sign), 64'd1);

    set_op(1, 3, 2, 32'hF123_4567, 0, 2, 1, 32'hABCD_EF01, 1, 0, 0, 1);
    step(1, 1); step(0, 1); step(0, 1);
    check("nar_flags", {62'd0, NaR, zero}, 64'd2);
    check("nar_fields", {PAD'(0), Sign, Scale, Mantissa, Sticky, 2'b00}, 64'd0);

    // Back-to-back three, downstream stalls cycles 3..5
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_op(i[0], i + 1, i, 32'h8000_0000 | 32'(i * 32'h1111_1111), 0, -i, 3 - i, 32'hC000_0001, 0, 0, 0, 0);
      step(1, 1);
    end
    step(0, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 6; i++) step(0, 1);
    check("b2b_count", 64'(delivered), 64'd3);
    check("b2b_empty", 64'(exp_q.size()), 64'd0);

    // Reset one cycle after accepting an input
    step(1, 1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      check("rst_flush", 64'(out_valid), 64'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      set_op(1'($urandom), int'($urandom_range(0, 61)) - 31, int'($urandom_range(0, 3)),
             32'h8000_0000 | 32'($urandom), 1'($urandom), int'($urandom_range(0, 61)) - 31,
             int'($urandom_range(0, 3)), 32'h8000_0000 | 32'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 10; i++) step(0, 1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=1 want=0");
    $fatal(1);
  end
endmodule
